// File: rtl/para_regbank.sv
// ---------------------------------------------------------------------------
// para_regbank
//
// Parametrised control/status register bank on the fx bus. One instance sits
// in each para_top sub-block and answers only to bus addresses whose device
// field [21:16] matches dev_id. The bank provides:
//   - a read-only id word at local address 0 (dev_id, zero-extended)
//   - N_CFG read/write config registers with per-register reset values
//   - N_STAT sticky status registers (level-set, write-1-to-clear)
//   - N_STAT interrupt-enable registers, one per status register
//   - a registered interrupt request and a registered read-valid strobe
//
// Parameters:
//   DW        data width of bus and registers (8 or 16)
//   N_CFG     number of config registers (1..64)
//   N_STAT    number of status / interrupt-enable registers (1..16)
//   CFG_BASE  local address of config register 0
//   STAT_BASE local address of status register 0
//   IEN_BASE  local address of interrupt-enable register 0
//   CFG_INIT  packed reset values, register i uses CFG_INIT[i*DW +: DW]
//
// Ports:
//   clk_sys   in   system clock, all logic on the rising edge
//   rst_n     in   synchronous active-low reset
//   dev_id    in   device id, matched against address bits [21:16]
//   fx_wr     in   write strobe, one cycle per write
//   fx_waddr  in   write address, [21:16] device, [15:0] local
//   fx_data   in   write data
//   fx_rd     in   read strobe, one cycle per read
//   fx_raddr  in   read address, same split as fx_waddr
//   fx_q      out  registered read data
//   fx_qv     out  read-valid, high one cycle per accepted read
//   cfg_out   out  packed config register contents
//   cfg_upd   out  one-cycle pulse per config register written
//   stat_set  in   per-bit event inputs, a high level sets the sticky bit
//   stat_irq  out  registered interrupt request
// ---------------------------------------------------------------------------
module para_regbank #(
    parameter int                  DW        = 8,
    parameter int                  N_CFG     = 8,
    parameter int                  N_STAT    = 4,
    parameter logic [15:0]         CFG_BASE  = 16'h0080,
    parameter logic [15:0]         STAT_BASE = 16'h0100,
    parameter logic [15:0]         IEN_BASE  = 16'h0180,
    parameter logic [N_CFG*DW-1:0] CFG_INIT  = '0
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic [5:0]           dev_id,
    input  logic                 fx_wr,
    input  logic [21:0]          fx_waddr,
    input  logic [DW-1:0]        fx_data,
    input  logic                 fx_rd,
    input  logic [21:0]          fx_raddr,
    output logic [DW-1:0]        fx_q,
    output logic                 fx_qv,
    output logic [N_CFG*DW-1:0]  cfg_out,
    output logic [N_CFG-1:0]     cfg_upd,
    input  logic [N_STAT*DW-1:0] stat_set,
    output logic                 stat_irq
);

    // -----------------------------------------------------------------------
    // Address-map sanity. Two windows [a, a+n) and [b, b+m) collide when
    // each one starts below the end of the other. The id word is treated as
    // a one-entry window at local address 0. A window that runs past the top
    // of the 16-bit local space would alias onto low addresses, so that is
    // rejected as well.
    // -----------------------------------------------------------------------
    function automatic bit spans_overlap(input int a_base, input int a_len,
                                         input int b_base, input int b_len);
        return (a_base < b_base + b_len) && (b_base < a_base + a_len);
    endfunction

    localparam int CFG_B  = int'(CFG_BASE);
    localparam int STAT_B = int'(STAT_BASE);
    localparam int IEN_B  = int'(IEN_BASE);

    localparam bit MAP_OVERLAP =
        spans_overlap(0,      1,      CFG_B,  N_CFG)  ||
        spans_overlap(0,      1,      STAT_B, N_STAT) ||
        spans_overlap(0,      1,      IEN_B,  N_STAT) ||
        spans_overlap(CFG_B,  N_CFG,  STAT_B, N_STAT) ||
        spans_overlap(CFG_B,  N_CFG,  IEN_B,  N_STAT) ||
        spans_overlap(STAT_B, N_STAT, IEN_B,  N_STAT);

    localparam bit MAP_WRAPS =
        (CFG_B  + N_CFG  > 65536) ||
        (STAT_B + N_STAT > 65536) ||
        (IEN_B  + N_STAT > 65536);

    // -----------------------------------------------------------------------
    // Register storage
    // -----------------------------------------------------------------------
    logic [DW-1:0] cfg_r  [N_CFG];
    logic [DW-1:0] stat_r [N_STAT];
    logic [DW-1:0] ien_r  [N_STAT];

    // -----------------------------------------------------------------------
    // Decode signals
    // -----------------------------------------------------------------------
    logic              wr_acc;
    logic              rd_acc;
    logic [15:0]       wr_local;
    logic [15:0]       rd_local;
    logic [N_CFG-1:0]  wr_cfg_hit;
    logic [N_STAT-1:0] wr_stat_hit;
    logic [N_STAT-1:0] wr_ien_hit;
    logic [DW-1:0]     stat_clr [N_STAT];
    logic [DW-1:0]     rd_data;
    logic              irq_next;

    // Device select: a strobe whose device field does not match dev_id is
    // not for this bank and must leave every register untouched.
    assign wr_acc   = fx_wr && (fx_waddr[21:16] == dev_id);
    assign rd_acc   = fx_rd && (fx_raddr[21:16] == dev_id);
    assign wr_local = fx_waddr[15:0];
    assign rd_local = fx_raddr[15:0];

    // -----------------------------------------------------------------------
    // Write decode: one hit bit per register. An accepted write to a local
    // address outside every window raises no hit and is silently dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_cfg_hit  = '0;
        wr_stat_hit = '0;
        wr_ien_hit  = '0;
        for (int i = 0; i < N_CFG; i++) begin
            wr_cfg_hit[i] = wr_acc && (wr_local == 16'(CFG_B + i));
        end
        for (int j = 0; j < N_STAT; j++) begin
            wr_stat_hit[j] = wr_acc && (wr_local == 16'(STAT_B + j));
            wr_ien_hit[j]  = wr_acc && (wr_local == 16'(IEN_B + j));
        end
    end

    // -----------------------------------------------------------------------
    // Write-1-to-clear masks: the write data selects which sticky bits to
    // drop, and only for the status register actually addressed.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < N_STAT; j++) begin
            stat_clr[j] = wr_stat_hit[j] ? fx_data : '0;
        end
    end

    // -----------------------------------------------------------------------
    // Read multiplexer. It looks at the current register contents, so a read
    // and a write to the same address in one cycle returns the old value.
    // Unmapped local addresses read as zero.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        if (rd_local == 16'h0000) begin
            rd_data = {{(DW-6){1'b0}}, dev_id};
        end
        for (int i = 0; i < N_CFG; i++) begin
            if (rd_local == 16'(CFG_B + i)) begin
                rd_data = cfg_r[i];
            end
        end
        for (int j = 0; j < N_STAT; j++) begin
            if (rd_local == 16'(STAT_B + j)) begin
                rd_data = stat_r[j];
            end
            if (rd_local == 16'(IEN_B + j)) begin
                rd_data = ien_r[j];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt source: any enabled sticky bit. This uses the registers as
    // they stand before the coming edge, which is what gives the interrupt
    // its extra cycle of latency behind the status bit.
    // -----------------------------------------------------------------------
    always_comb begin
        irq_next = 1'b0;
        for (int j = 0; j < N_STAT; j++) begin
            irq_next = irq_next | (|(stat_r[j] & ien_r[j]));
        end
    end

    // -----------------------------------------------------------------------
    // Config registers. cfg_upd is registered alongside the data so the
    // pulse lines up with the new value on cfg_out. Reset reloads CFG_INIT
    // and squashes any update pulse that a concurrent write would have made.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CFG; i++) begin
                cfg_r[i] <= CFG_INIT[i*DW +: DW];
            end
            cfg_upd <= '0;
        end else begin
            for (int i = 0; i < N_CFG; i++) begin
                cfg_upd[i] <= wr_cfg_hit[i];
                if (wr_cfg_hit[i]) begin
                    cfg_r[i] <= fx_data;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Status, interrupt-enable and interrupt request. The set term is OR-ed
    // in after the clear mask so an event arriving in the same cycle as its
    // own clear keeps the bit set, and a held event input keeps re-setting
    // it every cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            for (int j = 0; j < N_STAT; j++) begin
                stat_r[j] <= '0;
                ien_r[j]  <= '0;
            end
            stat_irq <= 1'b0;
        end else begin
            for (int j = 0; j < N_STAT; j++) begin
                stat_r[j] <= (stat_r[j] & ~stat_clr[j]) | stat_set[j*DW +: DW];
                if (wr_ien_hit[j]) begin
                    ien_r[j] <= fx_data;
                end
            end
            stat_irq <= irq_next;
        end
    end

    // -----------------------------------------------------------------------
    // Read response. fx_q is forced to zero whenever no response is being
    // given so the bus can be OR-combined across sub-blocks. Reset drops a
    // response that was about to be registered.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            fx_q  <= '0;
            fx_qv <= 1'b0;
        end else begin
            fx_q  <= rd_acc ? rd_data : '0;
            fx_qv <= rd_acc;
        end
    end

    // -----------------------------------------------------------------------
    // Packed view of the config registers for the surrounding sub-block.
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < N_CFG; g++) begin : g_cfg_out
        assign cfg_out[g*DW +: DW] = cfg_r[g];
    end

    // -----------------------------------------------------------------------
    // Simulation guard against a parameter set whose windows collide or wrap;
    // such a bank would decode one address into two registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin : map_check
        assert (!(MAP_OVERLAP || MAP_WRAPS))
            else $error("para_regbank: address windows overlap or wrap");
    end

endmodule

// File: tb/tb_para_regbank.sv
// ---------------------------------------------------------------------------
// tb_para_regbank
//
// Directed bench for para_regbank with eight 8-bit config registers preset
// to 80..87 and four status registers. Reads push their expected data onto a
// scoreboard queue when the strobe is driven; the response is popped and
// compared one edge later. Every cycle also confirms that fx_qv and fx_q stay
// low when no response is due.
// ---------------------------------------------------------------------------
module tb_para_regbank;

    localparam int          DW        = 8;
    localparam int          N_CFG     = 8;
    localparam int          N_STAT    = 4;
    localparam logic [15:0] CFG_BASE  = 16'h0080;
    localparam logic [15:0] STAT_BASE = 16'h0100;
    localparam logic [15:0] IEN_BASE  = 16'h0180;
    localparam logic [63:0] CFG_INIT  = 64'h8786_8584_8382_8180;
    localparam logic [5:0]  DEV       = 6'h15;
    localparam logic [5:0]  OTHER_DEV = 6'h16;

    logic                 clk_sys;
    logic                 rst_n;
    logic [5:0]           dev_id;
    logic                 fx_wr;
    logic [21:0]          fx_waddr;
    logic [DW-1:0]        fx_data;
    logic                 fx_rd;
    logic [21:0]          fx_raddr;
    logic [DW-1:0]        fx_q;
    logic                 fx_qv;
    logic [N_CFG*DW-1:0]  cfg_out;
    logic [N_CFG-1:0]     cfg_upd;
    logic [N_STAT*DW-1:0] stat_set;
    logic                 stat_irq;

    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    logic [DW-1:0] exp_q [$];
    bit rd_pending = 0;

    para_regbank #(
        .DW        (DW),
        .N_CFG     (N_CFG),
        .N_STAT    (N_STAT),
        .CFG_BASE  (CFG_BASE),
        .STAT_BASE (STAT_BASE),
        .IEN_BASE  (IEN_BASE),
        .CFG_INIT  (CFG_INIT)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .dev_id   (dev_id),
        .fx_wr    (fx_wr),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .fx_q     (fx_q),
        .fx_qv    (fx_qv),
        .cfg_out  (cfg_out),
        .cfg_upd  (cfg_upd),
        .stat_set (stat_set),
        .stat_irq (stat_irq)
    );

    // Free-running system clock, 10 time units per period.
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Single comparison point: counts the check and reports a miss.
    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    // Read-path check after each edge: a response is due exactly when an
    // accepted read was sampled at that edge.
    task automatic checkOutput();
        logic [DW-1:0] exp;
        if (rd_pending) begin
            exp = exp_q.pop_front();
            checkEq($sformatf("qv_rd%0d", rd_count), {63'd0, fx_qv}, 64'd1);
            checkEq($sformatf("q_rd%0d", rd_count), {56'd0, fx_q}, {56'd0, exp});
            rd_count++;
        end else begin
            checkEq("qv_idle", {63'd0, fx_qv}, 64'd0);
            checkEq("q_idle", {56'd0, fx_q}, 64'd0);
        end
    endtask

    // Drives one cycle of inputs, clocks it in, returns the bus to idle and
    // checks the read path. A read is scored only when it will be accepted.
    task automatic applyStimulus(input bit rstn, input bit wr, input logic [21:0] waddr,
                                 input logic [DW-1:0] wdata, input bit rd,
                                 input logic [21:0] raddr, input logic [DW-1:0] rexp,
                                 input logic [N_STAT*DW-1:0] set);
        rst_n    = rstn;
        fx_wr    = wr;
        fx_waddr = waddr;
        fx_data  = wdata;
        fx_rd    = rd;
        fx_raddr = raddr;
        stat_set = set;
        rd_pending = rstn && rd && (raddr[21:16] == DEV);
        if (rd_pending) exp_q.push_back(rexp);
        @(posedge clk_sys);
        #1;
        fx_wr    = 1'b0;
        fx_rd    = 1'b0;
        stat_set = '0;
        checkOutput();
        rd_pending = 0;
    endtask

    task automatic idle();
        applyStimulus(1, 0, 22'd0, 8'h00, 0, 22'd0, 8'h00, '0);
    endtask

    task automatic doWrite(input logic [21:0] addr, input logic [DW-1:0] data);
        applyStimulus(1, 1, addr, data, 0, 22'd0, 8'h00, '0);
    endtask

    task automatic doRead(input logic [21:0] addr, input logic [DW-1:0] exp);
        applyStimulus(1, 0, 22'd0, 8'h00, 1, addr, exp, '0);
    endtask

    task automatic pulseSet(input logic [N_STAT*DW-1:0] set);
        applyStimulus(1, 0, 22'd0, 8'h00, 0, 22'd0, 8'h00, set);
    endtask

    function automatic logic [21:0] la(input logic [5:0] dev, input logic [15:0] local_addr);
        return {dev, local_addr};
    endfunction

    // Directed sequence.
    initial begin
        dev_id   = DEV;
        rst_n    = 1'b0;
        fx_wr    = 1'b0;
        fx_waddr = '0;
        fx_data  = '0;
        fx_rd    = 1'b0;
        fx_raddr = '0;
        stat_set = '0;

        // Reset state
        applyStimulus(0, 0, 22'd0, 8'h00, 0, 22'd0, 8'h00, '0);
        applyStimulus(0, 0, 22'd0, 8'h00, 0, 22'd0, 8'h00, '0);
        checkEq("rst_cfg_out", cfg_out, CFG_INIT);
        checkEq("rst_cfg_upd", {56'd0, cfg_upd}, 64'd0);
        checkEq("rst_irq", {63'd0, stat_irq}, 64'd0);

        // Config reset values and id word, back to back
        for (int i = 0; i < N_CFG; i++) begin
            doRead(la(DEV, CFG_BASE + 16'(i)), 8'h80 + 8'(i));
        end
        doRead(la(DEV, 16'h0000), {2'b00, DEV});
        idle();

        // Config write with matching device
        doWrite(la(DEV, CFG_BASE + 16'd3), 8'hA5);
        checkEq("upd_pulse", {56'd0, cfg_upd}, 64'h08);
        checkEq("cfg3_new", {56'd0, cfg_out[31:24]}, 64'hA5);
        idle();
        checkEq("upd_single", {56'd0, cfg_upd}, 64'd0);
        doRead(la(DEV, CFG_BASE + 16'd3), 8'hA5);

        // Same write and read for another device: ignored
        doWrite(la(OTHER_DEV, CFG_BASE + 16'd3), 8'h5A);
        checkEq("upd_other_dev", {56'd0, cfg_upd}, 64'd0);
        checkEq("cfg3_other_dev", {56'd0, cfg_out[31:24]}, 64'hA5);
        applyStimulus(1, 0, 22'd0, 8'h00, 1, la(OTHER_DEV, CFG_BASE), 8'h00, '0);
        doRead(la(DEV, CFG_BASE + 16'd3), 8'hA5);

        // Sticky status and interrupt latency
        doWrite(la(DEV, IEN_BASE + 16'd1), 8'h04);
        pulseSet(32'h0000_0400);
        checkEq("irq_not_yet", {63'd0, stat_irq}, 64'd0);
        doRead(la(DEV, STAT_BASE + 16'd1), 8'h04);
        checkEq("irq_rise", {63'd0, stat_irq}, 64'd1);
        doWrite(la(DEV, STAT_BASE + 16'd1), 8'h04);
        checkEq("irq_hold_after_clr", {63'd0, stat_irq}, 64'd1);
        idle();
        checkEq("irq_fall", {63'd0, stat_irq}, 64'd0);
        doRead(la(DEV, STAT_BASE + 16'd1), 8'h00);

        // Set wins over a same-cycle clear
        pulseSet(32'h0000_0001);
        applyStimulus(1, 1, la(DEV, STAT_BASE), 8'h01, 0, 22'd0, 8'h00, 32'h0000_0001);
        doRead(la(DEV, STAT_BASE), 8'h01);
        doWrite(la(DEV, STAT_BASE), 8'h01);
        doRead(la(DEV, STAT_BASE), 8'h00);

        // Same-cycle read and write of config 0 returns the old value
        applyStimulus(1, 1, la(DEV, CFG_BASE), 8'h3C, 1, la(DEV, CFG_BASE), 8'h80, '0);
        checkEq("upd_cfg0", {56'd0, cfg_upd}, 64'h01);
        doRead(la(DEV, CFG_BASE), 8'h3C);

        // Unmapped read, then four reads back to back
        doRead(la(DEV, 16'h0050), 8'h00);
        doRead(la(DEV, CFG_BASE + 16'd1), 8'h81);
        doRead(la(DEV, CFG_BASE + 16'd3), 8'hA5);
        doRead(la(DEV, IEN_BASE + 16'd1), 8'h04);
        doRead(la(DEV, 16'h0000), {2'b00, DEV});
        idle();

        // Reset coinciding with a read, a write and an event
        doWrite(la(DEV, CFG_BASE + 16'd5), 8'hFF);
        applyStimulus(0, 1, la(DEV, CFG_BASE + 16'd2), 8'h11, 1, la(DEV, CFG_BASE + 16'd5),
                      8'h00, 32'h0000_0400);
        checkEq("rst2_cfg_upd", {56'd0, cfg_upd}, 64'd0);
        checkEq("rst2_cfg_out", cfg_out, CFG_INIT);
        checkEq("rst2_irq", {63'd0, stat_irq}, 64'd0);
        doRead(la(DEV, IEN_BASE + 16'd1), 8'h00);
        doRead(la(DEV, STAT_BASE + 16'd1), 8'h00);
        doRead(la(DEV, CFG_BASE + 16'd5), 8'h85);
        idle();
        checkEq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
